// File: rtl/cla_nibble_seq.sv
// Nibble-serial wide adder: one 4-bit carry-lookahead slice reused across WIDTH bits, with a registered inter-nibble carry.
// Optional macro CLA_SEQ_OVF_EN adds the signed-overflow output ovf.

module cla (
    output logic [3:0] sum,
    output logic       c_out,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in
);
    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_c;

    // Lookahead carries, each flattened to depend only on p/g and c_in.
    always_comb begin
        w_p    = a ^ b;
        w_g    = a & b;
        w_c[0] = c_in;
        w_c[1] = w_g[0] | (w_p[0] & c_in);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c_in);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & c_in);
        w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & c_in);
        sum    = w_p ^ w_c[3:0];
        c_out  = w_c[4];
    end
endmodule

module cla_nibble_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef CLA_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_width_check
        $error("cla_nibble_seq: WIDTH must be a multiple of 4 and at least 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;
    logic [3:0]         w_a_nib;
    logic [3:0]         w_b_nib;
    logic [3:0]         w_nib_sum;
    logic               w_nib_cout;
    logic               w_last;

    assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
    assign w_b_nib = r_b[{r_idx, 2'b00} +: 4];
    assign w_last  = (r_idx == IDX_W'(NIBBLES - 1));

    cla u_cla (
        .sum   (w_nib_sum),
        .c_out (w_nib_cout),
        .a     (w_a_nib),
        .b     (w_b_nib),
        .c_in  (r_carry)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) w_state_next = RUN;
                else          w_state_next = IDLE;
            end
            RUN: begin
                if (w_last) w_state_next = DONE;
                else        w_state_next = RUN;
            end
            DONE: begin
                if (out_ready) w_state_next = IDLE;
                else           w_state_next = DONE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture and nibble-serial result accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= c_in;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_sum[{r_idx, 2'b00} +: 4] <= w_nib_sum;
                    r_carry                    <= w_nib_cout;
                    if (w_last) begin
                        r_idx  <= '0;
                        r_cout <= w_nib_cout;
                        // Carry into the MSB is recovered from the top sum bit and its operands.
                        r_ovf  <= w_a_nib[3] ^ w_b_nib[3] ^ w_nib_sum[3] ^ w_nib_cout;
                    end else begin
                        r_idx  <= r_idx + IDX_W'(1);
                    end
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign c_out     = r_cout;
`ifdef CLA_SEQ_OVF_EN
    assign ovf       = r_ovf;
`else
    logic w_ovf_unused;
    assign w_ovf_unused = r_ovf;
`endif
endmodule

// File: tb/tb_cla_nibble_seq.sv
// Directed self-checking bench for cla_nibble_seq (WIDTH=16); ovf checks compile in with CLA_SEQ_OVF_EN.

module tb_cla_nibble_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        c_out;
`ifdef CLA_SEQ_OVF_EN
    logic        ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    cla_nibble_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out)
`ifdef CLA_SEQ_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Issue one operation from IDLE; report edges from the accept edge (inclusive) to out_valid.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                          output int edges, output bit saw_ready);
        @(negedge clk);
        a = ta; b = tb_v; c_in = tc; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        edges = 1;
        saw_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; c_in = 1'b1;
        while (!out_valid && edges < 20) begin
            if (in_ready) saw_ready = 1'b1;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic handoff();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 16'h0; b = 16'h0; c_in = 1'b0;
        #1;
        n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_tests++; if (sum !== 16'h0000)   begin n_fail++; $display("FAIL reset_sum got %h exp 0000", sum); end
        n_tests++; if (c_out !== 1'b0)     begin n_fail++; $display("FAIL reset_c_out got %b exp 0", c_out); end
`ifdef CLA_SEQ_OVF_EN
        n_tests++; if (ovf !== 1'b0)       begin n_fail++; $display("FAIL reset_ovf got %b exp 0", ovf); end
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int  e;
        bit  sr;
        run_op(16'h1234, 16'h4321, 1'b0, e, sr);
        n_tests++; if (e != 5)           begin n_fail++; $display("FAIL basic_latency got %0d exp 5", e); end
        n_tests++; if (sr !== 1'b0)      begin n_fail++; $display("FAIL basic_in_ready_run got %b exp 0", sr); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_in_ready_done got %b exp 0", in_ready); end
        n_tests++; if (sum !== 16'h5555) begin n_fail++; $display("FAIL basic_sum got %h exp 5555", sum); end
        n_tests++; if (c_out !== 1'b0)   begin n_fail++; $display("FAIL basic_c_out got %b exp 0", c_out); end
        handoff();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_valid got %b exp 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL basic_idle_ready got %b exp 1", in_ready); end
        n_tests++; if (sum !== 16'h5555)   begin n_fail++; $display("FAIL basic_sum_held got %h exp 5555", sum); end
    endtask

    task automatic test_carry();
        logic [15:0] va [4] = '{16'hFFFF, 16'hFFFF, 16'hABCD, 16'h5A5A};
        logic [15:0] vb [4] = '{16'h0001, 16'h0000, 16'h1357, 16'hA5A5};
        logic        vc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [15:0] es [4] = '{16'h0000, 16'h0000, 16'hBF25, 16'hFFFF};
        logic        ec [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        int e;
        bit sr;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vc[i], e, sr);
            n_tests++; if (sum !== es[i])  begin n_fail++; $display("FAIL carry_sum[%0d] got %h exp %h", i, sum, es[i]); end
            n_tests++; if (c_out !== ec[i]) begin n_fail++; $display("FAIL carry_c_out[%0d] got %b exp %b", i, c_out, ec[i]); end
            handoff();
        end
    endtask

    task automatic test_backpressure();
        int e;
        bit sr;
        run_op(16'h0F0F, 16'h00F1, 1'b0, e, sr);
        for (int i = 0; i < 3; i++) begin
            in_valid = (i != 1); a = 16'h1111; b = 16'h2222;
            @(posedge clk);
            @(negedge clk);
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b exp 1", i, out_valid); end
            n_tests++; if (sum !== 16'h1000)   begin n_fail++; $display("FAIL bp_sum[%0d] got %h exp 1000", i, sum); end
            n_tests++; if (c_out !== 1'b0)     begin n_fail++; $display("FAIL bp_c_out[%0d] got %b exp 0", i, c_out); end
            n_tests++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b exp 0", i, in_ready); end
        end
        in_valid = 1'b0;
        handoff();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b exp 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 16'h8000; b = 16'h8000;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid1 got %b exp 1", out_valid); end
        n_tests++; if (sum !== 16'h0002)   begin n_fail++; $display("FAIL b2b_sum1 got %h exp 0002", sum); end
        n_tests++; if (c_out !== 1'b0)     begin n_fail++; $display("FAIL b2b_c_out1 got %b exp 0", c_out); end
        @(posedge clk);
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_valid got %b exp 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL b2b_idle_ready got %b exp 1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        n_tests++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL b2b_accept2 got %b exp 0", in_ready); end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid2 got %b exp 1", out_valid); end
        n_tests++; if (sum !== 16'h0000)   begin n_fail++; $display("FAIL b2b_sum2 got %h exp 0000", sum); end
        n_tests++; if (c_out !== 1'b1)     begin n_fail++; $display("FAIL b2b_c_out2 got %b exp 1", c_out); end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_mid_reset();
        int e;
        bit sr;
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++; if (sum !== 16'h00FF) begin n_fail++; $display("FAIL midrst_partial got %h exp 00ff", sum); end
        rst = 1'b1;
        #1;
        n_tests++; if (sum !== 16'h0000)   begin n_fail++; $display("FAIL midrst_sum got %h exp 0000", sum); end
        n_tests++; if (c_out !== 1'b0)     begin n_fail++; $display("FAIL midrst_c_out got %b exp 0", c_out); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b exp 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL midrst_ready got %b exp 1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        run_op(16'h0003, 16'h0004, 1'b0, e, sr);
        n_tests++; if (e != 5)           begin n_fail++; $display("FAIL midrst_latency got %0d exp 5", e); end
        n_tests++; if (sum !== 16'h0007) begin n_fail++; $display("FAIL midrst_next_sum got %h exp 0007", sum); end
        n_tests++; if (c_out !== 1'b0)   begin n_fail++; $display("FAIL midrst_next_c_out got %b exp 0", c_out); end
        handoff();
    endtask

`ifdef CLA_SEQ_OVF_EN
    task automatic test_ovf();
        int e;
        bit sr;
        run_op(16'h7FFF, 16'h0001, 1'b0, e, sr);
        n_tests++; if (sum !== 16'h8000) begin n_fail++; $display("FAIL ovf1_sum got %h exp 8000", sum); end
        n_tests++; if (c_out !== 1'b0)   begin n_fail++; $display("FAIL ovf1_c_out got %b exp 0", c_out); end
        n_tests++; if (ovf !== 1'b1)     begin n_fail++; $display("FAIL ovf1_ovf got %b exp 1", ovf); end
        handoff();
        n_tests++; if (ovf !== 1'b1)     begin n_fail++; $display("FAIL ovf1_held got %b exp 1", ovf); end
        run_op(16'hFFFF, 16'h0001, 1'b0, e, sr);
        n_tests++; if (sum !== 16'h0000) begin n_fail++; $display("FAIL ovf2_sum got %h exp 0000", sum); end
        n_tests++; if (c_out !== 1'b1)   begin n_fail++; $display("FAIL ovf2_c_out got %b exp 1", c_out); end
        n_tests++; if (ovf !== 1'b0)     begin n_fail++; $display("FAIL ovf2_ovf got %b exp 0", ovf); end
        handoff();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
`ifdef CLA_SEQ_OVF_EN
        test_ovf();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule
